// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. A round-robin
// arbiter grants one request at a time. The operation runs through a
// three-state sequence: IDLE (grant and latch) -> EXEC (drive the ALU, capture
// its outputs) -> RESP (hold the response until the consumer accepts it).
//
// Ports
//   clk, reset_n                 clock; synchronous active-low reset
//   reqN_valid / reqN_ready      requester handshake (N = 0,1)
//   reqN_a, reqN_b, reqN_op      requester operands and 4-bit opcode
//   alu_a, alu_b, alu_op         drive the shared ALU (zero outside EXEC)
//   alu_result, alu_zero         shared ALU outputs, captured in EXEC
//   rsp_valid / rsp_ready        response handshake
//   rsp_id                       which requester the response belongs to
//   rsp_result, rsp_zero, rsp_err  response payload (err = illegal opcode)
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_op,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_op,

   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,

   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic             ptr;        // requester that wins when both are valid
   logic             any_valid;
   logic             grant_id;
   logic             grant;

   logic [WIDTH-1:0] lat_a;
   logic [WIDTH-1:0] lat_b;
   logic [3:0]       lat_op;
   logic             lat_id;
   logic             lat_legal;

   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0100: is_legal = 1'b1;
         default:                                               is_legal = 1'b0;
      endcase
   endfunction

   assign any_valid = req0_valid | req1_valid;
   // Contention goes to the pointer; otherwise the lone valid requester wins.
   assign grant_id  = (req0_valid && req1_valid) ? ptr : req1_valid;
   assign grant     = (state == IDLE) && any_valid && reset_n;
   assign lat_legal = is_legal(lat_op);

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement can leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      alu_a      = '0;
      alu_b      = '0;
      alu_op     = 4'b0000;
      rsp_valid  = 1'b0;

      case (state)
         IDLE: begin
            if (any_valid) begin
               req0_ready = ~grant_id;
               req1_ready = grant_id;
               state_nxt  = EXEC;
            end
         end
         EXEC: begin
            // Illegal opcodes leave the ALU inputs at their idle zero values.
            if (lat_legal) begin
               alu_a  = lat_a;
               alu_b  = lat_b;
               alu_op = lat_op;
            end
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Reset overrides the handshake and the ALU drive in the same cycle.
      if (!reset_n) begin
         req0_ready = 1'b0;
         req1_ready = 1'b0;
         alu_a      = '0;
         alu_b      = '0;
         alu_op     = 4'b0000;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         ptr        <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant) ptr <= ~grant_id;
         if (state == EXEC) begin
            rsp_id <= lat_id;
            if (lat_legal) begin
               rsp_result <= alu_result;
               rsp_zero   <= alu_zero;
               rsp_err    <= 1'b0;
            end else begin
               rsp_result <= '0;
               rsp_zero   <= 1'b1;
               rsp_err    <= 1'b1;
            end
         end
      end
   end

   // NOTE: the operand latches carry no reset; they are always written at a
   // grant before EXEC ever reads them, so resetting them buys nothing.
   always_ff @(posedge clk) begin
      if (grant) begin
         lat_id <= grant_id;
         lat_a  <= grant_id ? req1_a  : req0_a;
         lat_b  <= grant_id ? req1_b  : req0_b;
         lat_op <= grant_id ? req1_op : req0_op;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. A behavioural model of the shared ALU
// answers the DUT's alu_* drive. Directed vectors with hand-computed results
// are applied from a table; handwritten sequences cover contention, response
// backpressure, reset while a response is pending and operand changes after
// a grant.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          req0_valid, req1_valid;
   logic          req0_ready, req1_ready;
   logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic [3:0]    req0_op, req1_op;
   logic [W-1:0]  alu_a, alu_b, alu_result;
   logic [3:0]    alu_op;
   logic          alu_zero;
   logic          rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
   logic [W-1:0]  rsp_result;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err)
   );

   // Model of the external shared ALU.
   always_comb begin
      alu_result = '0;
      case (alu_op)
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b0010: alu_result = alu_a + alu_b;
         4'b0110: alu_result = alu_a - alu_b;
         4'b1100: alu_result = ~(alu_a | alu_b);
         4'b0100: alu_result = (alu_a < alu_b) ? 64'd0 : 64'd1;
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   typedef struct {
      logic         who;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   op;
      logic [W-1:0] exp_res;
      logic         exp_zero;
      logic         exp_err;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_op = 4'b0000;
      req1_a = '0; req1_b = '0; req1_op = 4'b0000;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   // Waits (bounded) for a ready at a negedge; reports which requester won.
   task automatic wait_grant(output int who);
      who = -1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("single_ready", {63'd0, req0_ready & req1_ready}, 64'd0);
         if (req0_ready) begin who = 0; break; end
         if (req1_ready) begin who = 1; break; end
      end
      if (who < 0) begin
         checks++;
         failures++;
         $display("FAIL grant_timeout: got no ready expected a grant within 8 cycles");
      end
   endtask

   // One full transaction on a single requester; optionally scrambles the
   // requester's inputs right after the grant.
   task automatic run_vec(input vec_t v, input bit tamper, input string tag);
      int who;
      @(posedge clk); #1;
      idle_inputs();
      if (v.who) begin
         req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
      end else begin
         req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
      end
      wait_grant(who);
      check({tag, "_grant_id"}, 64'(who), 64'(v.who));
      @(posedge clk); #1;
      if (tamper) begin
         req0_a = 64'd100; req0_b = 64'd1; req0_op = 4'b0000;
         req1_a = 64'd100; req1_b = 64'd1; req1_op = 4'b0000;
      end else begin
         idle_inputs();
      end
      @(negedge clk);   // EXEC
      check({tag, "_exec_alu_a"},  alu_a, v.exp_err ? '0 : v.a);
      check({tag, "_exec_alu_b"},  alu_b, v.exp_err ? '0 : v.b);
      check({tag, "_exec_alu_op"}, 64'(alu_op), v.exp_err ? 64'd0 : 64'(v.op));
      check({tag, "_exec_rsp_valid"}, 64'(rsp_valid), 64'd0);
      @(negedge clk);   // RESP
      check({tag, "_rsp_valid"},  64'(rsp_valid), 64'd1);
      check({tag, "_rsp_id"},     64'(rsp_id), 64'(v.who));
      check({tag, "_rsp_result"}, rsp_result, v.exp_res);
      check({tag, "_rsp_zero"},   64'(rsp_zero), 64'(v.exp_zero));
      check({tag, "_rsp_err"},    64'(rsp_err), 64'(v.exp_err));
      idle_inputs();
      @(negedge clk);   // back in IDLE
      check({tag, "_outside_alu_op"}, 64'(alu_op), 64'd0);
      check({tag, "_idle_rsp_valid"}, 64'(rsp_valid), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int who;
      vec_t tv;

      vecs[0] = '{1'b0, 64'd5, 64'd3, 4'b0110, 64'd2, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 64'hF, 64'h0, 4'b0000, 64'd0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'd0, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 64'hA0, 64'h0B, 4'b0001, 64'hAB, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 64'd0, 64'd0, 4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 64'd3, 64'd5, 4'b0100, 64'd0, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 64'd5, 64'd3, 4'b0100, 64'd1, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 64'hFFFF, 64'd0, 4'b1111, 64'd0, 1'b1, 1'b1};
      vecs[8] = '{1'b0, 64'h8000_0000_0000_0000, 64'd1, 4'b0110, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[9] = '{1'b0, 64'd7, 64'd7, 4'b0011, 64'd0, 1'b1, 1'b1};

      // ---- reset state, with both requesters pushing during reset ----
      idle_inputs();
      rsp_ready  = 1'b1;
      reset_n    = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_req0_ready", 64'(req0_ready), 64'd0);
      check("rst_req1_ready", 64'(req1_ready), 64'd0);
      check("rst_alu_a",      alu_a, 64'd0);
      check("rst_alu_op",     64'(alu_op), 64'd0);
      check("rst_rsp_valid",  64'(rsp_valid), 64'd0);
      check("rst_rsp_result", rsp_result, 64'd0);
      check("rst_rsp_id",     64'(rsp_id), 64'd0);
      check("rst_rsp_zero",   64'(rsp_zero), 64'd0);
      check("rst_rsp_err",    64'(rsp_err), 64'd0);
      @(posedge clk); #1;
      idle_inputs();
      reset_n = 1'b1;

      // ---- directed vector table ----
      for (int i = 0; i < 10; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

      // ---- operands changed right after grant ----
      tv = '{1'b0, 64'd10, 64'd4, 4'b0110, 64'd6, 1'b0, 1'b0};
      run_vec(tv, 1'b1, "tamper0");
      tv = '{1'b1, 64'd12, 64'd10, 4'b0010, 64'd22, 1'b0, 1'b0};
      run_vec(tv, 1'b1, "tamper1");

      // ---- contention: alternating grants starting with req0 after reset ----
      apply_reset();
      req0_valid = 1'b1; req0_a = 64'd1;   req0_b = 64'd1; req0_op = 4'b0010;
      req1_valid = 1'b1; req1_a = 64'hF;   req1_b = 64'h0; req1_op = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         wait_grant(who);
         check($sformatf("cont%0d_grant", k), 64'(who), 64'(k % 2));
         @(negedge clk);   // EXEC
         check($sformatf("cont%0d_exec_ready", k), 64'(req0_ready | req1_ready), 64'd0);
         @(negedge clk);   // RESP
         check($sformatf("cont%0d_rsp_id", k),     64'(rsp_id), 64'(k % 2));
         check($sformatf("cont%0d_rsp_result", k), rsp_result, (k % 2) ? 64'd0 : 64'd2);
         check($sformatf("cont%0d_rsp_zero", k),   64'(rsp_zero), (k % 2) ? 64'd1 : 64'd0);
         check($sformatf("cont%0d_resp_ready", k), 64'(req0_ready | req1_ready), 64'd0);
      end
      idle_inputs();

      // ---- backpressure: response held for 5 cycles, requesters starved ----
      @(posedge clk); #1;
      rsp_ready  = 1'b0;
      req0_valid = 1'b1; req0_a = 64'd9; req0_b = 64'd4; req0_op = 4'b0110;
      wait_grant(who);
      check("bp_grant", 64'(who), 64'd0);
      @(posedge clk); #1;
      req1_valid = 1'b1; req1_a = 64'd1; req1_b = 64'd1; req1_op = 4'b0010;
      @(negedge clk);   // EXEC
      @(negedge clk);   // RESP
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp%0d_rsp_valid", i),  64'(rsp_valid), 64'd1);
         check($sformatf("bp%0d_rsp_result", i), rsp_result, 64'd5);
         check($sformatf("bp%0d_rsp_id", i),     64'(rsp_id), 64'd0);
         check($sformatf("bp%0d_rsp_err", i),    64'(rsp_err), 64'd0);
         check($sformatf("bp%0d_no_ready", i),   64'(req0_ready | req1_ready), 64'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_accept_no_ready", 64'(req0_ready | req1_ready), 64'd0);
      check("bp_accept_valid",    64'(rsp_valid), 64'd1);
      @(negedge clk);   // IDLE
      check("bp_after_valid",  64'(rsp_valid), 64'd0);
      check("bp_after_retain", rsp_result, 64'd5);
      check("bp_after_grant",  64'(req0_ready | req1_ready), 64'd1);
      idle_inputs();
      reset_n = 1'b0;
      #1;
      check("bp_reset_gates_ready", 64'(req0_ready | req1_ready), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // ---- reset while a response is pending ----
      @(posedge clk); #1;
      rsp_ready  = 1'b0;
      req0_valid = 1'b1; req0_a = 64'd5; req0_b = 64'd3; req0_op = 4'b0110;
      wait_grant(who);
      check("rr_grant", 64'(who), 64'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);   // EXEC
      @(negedge clk);   // RESP
      check("rr_pre_valid",  64'(rsp_valid), 64'd1);
      check("rr_pre_result", rsp_result, 64'd2);
      reset_n    = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_op = 4'b0010; req0_a = 64'd1; req0_b = 64'd1;
      req1_op = 4'b0000; req1_a = 64'hF; req1_b = 64'h0;
      @(negedge clk);
      check("rr_valid",  64'(rsp_valid), 64'd0);
      check("rr_result", rsp_result, 64'd0);
      check("rr_ready",  64'(req0_ready | req1_ready), 64'd0);
      @(posedge clk); #1;
      reset_n   = 1'b1;
      rsp_ready = 1'b1;
      wait_grant(who);
      check("rr_first_grant", 64'(who), 64'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      check("rr_new_rsp_id",     64'(rsp_id), 64'd0);
      check("rr_new_rsp_result", rsp_result, 64'd2);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
